sparse_mac2: RTL and testbench
==============================

// Module: sparse_mac2
// PURPOSE
//  Downstream consumer of the 2:4 nonzero-select stage. Each accepted beat is
//  one group of four activations compressed to two operands (ain_0, ain_1),
//  plus their two compressed weights. The block multiplies each pair, sums the
//  two products and accumulates over a dot product that ends on in_last.
//  It then emits the accumulated result on a valid/ready output.
// PARAMETERS
//  DW      16  operand width; ain_*/w_* are signed two's complement
//  ACC_W   40  accumulator/result width (>= 2*DW+1)
//  CNT_W   8   width of group counter; max 2^CNT_W-1 groups per dot product
// PORTS
//  clk        in   1      clock, rising edge
//  rst_n      in   1      asynchronous reset, active low
//  in_valid   in   1      input beat valid
//  in_ready   out  1      block can accept a beat
//  in_last    in   1      beat is last group of the current dot product
//  ain_0      in   DW     first selected activation (0 if none selected)
//  ain_1      in   DW     second selected activation (0 if none selected)
//  w_0        in   DW     weight paired with ain_0
//  w_1        in   DW     weight paired with ain_1
//  out_valid  out  1      result valid; held until out_ready
//  out_ready  in   1      downstream accepts result
//  out_data   out  ACC_W  signed saturated dot-product result
//  out_cnt    out  CNT_W  number of groups accumulated into out_data
//  out_ovf    out  1      saturation occurred in this dot product
// BEHAVIOUR
//  Reset (rst_n=0, async): all pipeline valids, acc, counters, out_* clear to 0;
//   in_ready=1 one cycle after rst_n deasserts. FSM goes to IDLE.
//  stall = out_valid & ~out_ready; in_ready = ~stall (combinational).
//   While stall is high, S1 and S2 hold their state.
//  Input accepted when in_valid & in_ready.
//  S1 (mult): on accept, register p0=ain_0*w_0, p1=ain_1*w_1 (signed, 2*DW).
//   Also register v1=1 and last1=in_last. Otherwise v1=0 unless stalled.
//  S2 (accum): when v1 & ~stall:
//   sum = sext(p0)+sext(p1), (2*DW+1) bits;
//   nxt = (FSM==IDLE ? 0 : acc) + sext(sum);
//   saturate nxt to ACC_W signed range and set ovf_acc on clip.
//   cnt increments with saturation at all-ones.
//  FSM: IDLE (no partial sum), RUN (partial sum held in acc).
//   IDLE --beat, !last1--> RUN; RUN --beat, last1--> IDLE;
//   a beat with last1 in either state --> IDLE.
//  On a last1 beat:
//   out_data <= saturated nxt; out_cnt <= cnt+1; out_ovf <= ovf_acc|clip;
//   out_valid <= 1; acc, cnt and ovf_acc clear.
//  Latency: a last beat accepted in cycle t gives out_valid=1 in cycle t+2.
//   Throughput: 1 beat/cycle with no stall.
//  out_valid clears on out_valid & out_ready unless a new result loads in the
//   same cycle; in that case the new result replaces the old with no bubble.
//  A stall never drops or duplicates a beat. out_* are stable while stalled.
//  Zero operands (empty nonzero slot) add 0 and still count as a group.
//  Reset mid dot product discards the partial sum and any held result.
// TESTING
//  1 beat, ain=(3,-2), w=(4,5), last=1 -> out_data=2 at t+2, out_cnt=1, ovf=0
//  4 beats, ain=(1,2), w=(1,1) each, last on 4th, out_ready=1
//   -> out_data=12, out_cnt=4, in_ready stays 1
//  Two back-to-back 1-beat dot products (5*5, 7*7), out_ready=0 for 5 cycles
//   -> in_ready=0 while held, out_data=25 then 49, none lost
//  Beats of (-32768*-32768)x2 repeated until ACC_W limit, ACC_W=34
//   -> out_data=2^33-1, out_ovf=1; next dot product has ovf=0
//  Reset asserted after 2 of 3 beats -> outputs 0 immediately;
//   next 1-beat (2*3) -> out_data=6, out_cnt=1
//  Random valid/ready gaps, 1000 dot products vs. reference model
//   -> exact match of data, cnt, ovf

Source files
------------

// File: rtl/sparse_mac2.sv
// sparse_mac2: multiply-accumulate stage behind the 2:4 nonzero-select stage.
//
// Each accepted beat carries one group of four activations reduced to two
// operands (ain_0, ain_1) and their weights (w_0, w_1). The block forms both
// products, adds them, and accumulates the group sums of one dot product. The
// dot product ends on the beat marked in_last, and its saturated result is then
// presented on the output.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready     input beat handshake
//   in_last               beat closes the current dot product
//   ain_0, ain_1          signed selected activations (0 for an empty slot)
//   w_0, w_1              signed weights paired with ain_0 / ain_1
//   out_valid/out_ready   result handshake
//   out_data              signed saturated dot-product result
//   out_cnt               number of groups accumulated (saturates at all-ones)
//   out_ovf               accumulation clipped somewhere in this dot product
//   dbg_state             accumulator FSM state (0 = IDLE, 1 = RUN)
//
// Handshake: a transfer happens on a rising edge where valid and ready are both
// high. A producer holds valid and its payload steady until that edge. in_ready
// depends only on registered state and out_ready. A result is held on out_*
// unchanged until it is taken.
//
// Pipeline: S1 registers the two products. S2 adds them into the accumulator
// and loads the result register. A held result (out_valid & ~out_ready) freezes
// S1 and S2, so no beat is dropped or duplicated.
module sparse_mac2 #(
   parameter int DW    = 16,
   parameter int ACC_W = 40,
   parameter int CNT_W = 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic                    in_last,
   input  logic signed [DW-1:0]    ain_0,
   input  logic signed [DW-1:0]    ain_1,
   input  logic signed [DW-1:0]    w_0,
   input  logic signed [DW-1:0]    w_1,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic signed [ACC_W-1:0] out_data,
   output logic [CNT_W-1:0]        out_cnt,
   output logic                    out_ovf,
   output logic                    dbg_state
);

   localparam int PW = 2 * DW;      // product width
   localparam int SW = 2 * DW + 1;  // width of the sum of two products

   localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   // Registered state
   state_t                  state_q, state_d;
   logic                    v1_q, v1_d;
   logic                    last1_q, last1_d;
   logic signed [PW-1:0]    p0_q, p0_d;
   logic signed [PW-1:0]    p1_q, p1_d;
   logic signed [ACC_W-1:0] acc_q, acc_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic                    ovf_acc_q, ovf_acc_d;
   logic                    out_valid_q, out_valid_d;
   logic signed [ACC_W-1:0] out_data_q, out_data_d;
   logic [CNT_W-1:0]        out_cnt_q, out_cnt_d;
   logic                    out_ovf_q, out_ovf_d;

   // Datapath
   logic                    stall;
   logic                    accept;
   logic                    s2_fire;
   logic signed [SW-1:0]    sum;
   logic signed [ACC_W-1:0] base;
   logic signed [ACC_W:0]   nxt;
   logic                    clip;
   logic signed [ACC_W-1:0] nxt_sat;
   logic [CNT_W-1:0]        cnt_inc;

   assign stall    = out_valid_q & ~out_ready;
   assign in_ready = ~stall;
   assign accept   = in_valid & in_ready;
   assign s2_fire  = v1_q & ~stall;

   // The sign bit is repeated once so that adding two products cannot overflow.
   assign sum  = {p0_q[PW-1], p0_q} + {p1_q[PW-1], p1_q};
   // In IDLE no partial sum is live, so the accumulator is ignored.
   assign base = (state_q == IDLE) ? '0 : acc_q;
   // One guard bit above ACC_W exposes overflow of the accumulate.
   assign nxt  = {base[ACC_W-1], base} + {{(ACC_W+1-SW){sum[SW-1]}}, sum};
   assign clip = nxt[ACC_W] ^ nxt[ACC_W-1];
   assign nxt_sat = clip ? (nxt[ACC_W] ? ACC_MIN : ACC_MAX) : nxt[ACC_W-1:0];
   assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

   always_comb begin
      state_d     = state_q;
      v1_d        = v1_q;
      last1_d     = last1_q;
      p0_d        = p0_q;
      p1_d        = p1_q;
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      ovf_acc_d   = ovf_acc_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_cnt_d   = out_cnt_q;
      out_ovf_d   = out_ovf_q;

      // S1: the product registers are written only by a new beat.
      if (!stall) begin
         v1_d = accept;
         if (accept) begin
            p0_d    = ain_0 * w_0;
            p1_d    = ain_1 * w_1;
            last1_d = in_last;
         end
      end

      // The result is taken first. A result loaded in the same cycle overrides
      // this clear, so back-to-back results have no gap between them.
      if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end

      // S2: accumulate, or close the dot product.
      if (s2_fire) begin
         if (last1_q) begin
            out_valid_d = 1'b1;
            out_data_d  = nxt_sat;
            out_cnt_d   = cnt_inc;
            out_ovf_d   = ovf_acc_q | clip;
            acc_d       = '0;
            cnt_d       = '0;
            ovf_acc_d   = 1'b0;
            state_d     = IDLE;
         end else begin
            acc_d       = nxt_sat;
            cnt_d       = cnt_inc;
            ovf_acc_d   = ovf_acc_q | clip;
            state_d     = RUN;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         v1_q        <= 1'b0;
         last1_q     <= 1'b0;
         p0_q        <= '0;
         p1_q        <= '0;
         acc_q       <= '0;
         cnt_q       <= '0;
         ovf_acc_q   <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_cnt_q   <= '0;
         out_ovf_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         v1_q        <= v1_d;
         last1_q     <= last1_d;
         p0_q        <= p0_d;
         p1_q        <= p1_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         ovf_acc_q   <= ovf_acc_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_cnt_q   <= out_cnt_d;
         out_ovf_q   <= out_ovf_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_cnt   = out_cnt_q;
   assign out_ovf   = out_ovf_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_sparse_mac2.sv
// Bench for sparse_mac2. Inputs and out_ready change on the falling edge, and
// the DUT is observed a short time after the falling edge. Results are
// predicted by a model of the dot product, queued as {ovf, cnt, data} when the
// closing beat is accepted, and compared while the DUT presents them.
module tb_sparse_mac2;

   localparam int DW    = 16;
   localparam int ACC_W = 34;
   localparam int CNT_W = 8;
   localparam int EW    = ACC_W + CNT_W + 1;

   localparam longint SMAX = (64'sd1 <<< (ACC_W - 1)) - 64'sd1;
   localparam longint SMIN = -(64'sd1 <<< (ACC_W - 1));
   localparam logic [ACC_W-1:0] SAT_MAX = {1'b0, {(ACC_W-1){1'b1}}};

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic             in_last = 1'b0;
   logic [DW-1:0]    ain_0 = '0, ain_1 = '0, w_0 = '0, w_1 = '0;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [ACC_W-1:0] out_data;
   logic [CNT_W-1:0] out_cnt;
   logic             out_ovf;
   logic             dbg_state;

   int total = 0;
   int bad   = 0;

   logic [EW-1:0] exp_q[$];
   longint        m_acc = 0;
   int            m_cnt = 0;
   bit            m_ovf = 1'b0;
   bit            rdy_rand = 1'b0;

   sparse_mac2 #(.DW(DW), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
      .ain_0(ain_0), .ain_1(ain_1), .w_0(w_0), .w_1(w_1),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_cnt(out_cnt), .out_ovf(out_ovf),
      .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   task automatic model_beat(input logic signed [DW-1:0] a0, a1, b0, b1,
                             input bit last);
      longint s;
      s = m_acc + longint'(a0) * longint'(b0) + longint'(a1) * longint'(b1);
      if (s > SMAX) begin s = SMAX; m_ovf = 1'b1; end
      else if (s < SMIN) begin s = SMIN; m_ovf = 1'b1; end
      if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
      if (last) begin
         exp_q.push_back({m_ovf, m_cnt[CNT_W-1:0], s[ACC_W-1:0]});
         m_acc = 0; m_cnt = 0; m_ovf = 1'b0;
      end else begin
         m_acc = s;
      end
   endtask

   task automatic model_clear();
      exp_q.delete();
      m_acc = 0; m_cnt = 0; m_ovf = 1'b0;
   endtask

   // ---------------- driver ----------------
   // Presents one beat and returns just before the rising edge that accepts it.
   task automatic send_beat(input logic [DW-1:0] a0, a1, b0, b1, input bit last);
      int n = 0;
      @(negedge clk);
      in_valid = 1'b1; in_last = last;
      ain_0 = a0; ain_1 = a1; w_0 = b0; w_1 = b1;
      #1;
      while (!in_ready && n < 200) begin
         @(negedge clk); #1; n++;
      end
      if (!in_ready) begin
         total++; bad++;
         $display("FAIL send_timeout: in_ready=%b after %0d cycles, required 1", in_ready, n);
      end else begin
         model_beat(a0, a1, b0, b1, last);
      end
   endtask

   function automatic logic [DW-1:0] rnd_op();
      if ($urandom_range(0, 3) == 0) return DW'($urandom);
      return DW'($urandom_range(0, 400)) - DW'(200);
   endfunction

   always @(negedge clk) begin
      if (rdy_rand) out_ready = ($urandom_range(0, 99) < 70);
   end

   // ---------------- scoreboard monitor ----------------
   always @(negedge clk) begin
      #2;
      if (rst_n && out_valid) begin
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL sb_unexpected: data=%0d cnt=%0d ovf=%b, required no result",
                     $signed(out_data), out_cnt, out_ovf);
         end else if ({out_ovf, out_cnt, out_data} !== exp_q[0]) begin
            bad++;
            $display("FAIL sb_result: data=%0d cnt=%0d ovf=%b, required data=%0d cnt=%0d ovf=%b",
                     $signed(out_data), out_cnt, out_ovf, $signed(exp_q[0][ACC_W-1:0]),
                     exp_q[0][ACC_W+CNT_W-1:ACC_W], exp_q[0][EW-1]);
         end
         if (out_ready && exp_q.size() != 0) void'(exp_q.pop_front());
      end
   end

   task automatic drain();
      int n = 0;
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b1;
      while ((exp_q.size() != 0 || out_valid) && n < 500) begin
         @(negedge clk); n++;
      end
      total++;
      if (exp_q.size() != 0 || out_valid) begin
         bad++;
         $display("FAIL drain: pending=%0d out_valid=%b, required 0 and 0", exp_q.size(), out_valid);
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      total++;
      if ({out_valid, out_data, out_cnt, out_ovf, dbg_state} !== '0) begin
         bad++;
         $display("FAIL reset_outputs: valid=%b data=%0d cnt=%0d ovf=%b state=%b, required all 0",
                  out_valid, out_data, out_cnt, out_ovf, dbg_state);
      end
      @(negedge clk); rst_n = 1'b1;
      @(negedge clk); #1;
      total++;
      if (in_ready !== 1'b1) begin
         bad++; $display("FAIL reset_in_ready: in_ready=%b, required 1", in_ready);
      end
   endtask

   task automatic test_single();
      out_ready = 1'b0;
      send_beat(16'd3, -16'sd2, 16'd4, 16'd5, 1'b1);
      @(negedge clk); in_valid = 1'b0; #1;
      total++;
      if (out_valid !== 1'b0) begin
         bad++; $display("FAIL single_t1: out_valid=%b, required 0", out_valid);
      end
      @(negedge clk); #1;
      total++;
      if (out_valid !== 1'b1 || out_data !== ACC_W'(2) || out_cnt !== CNT_W'(1) || out_ovf !== 1'b0) begin
         bad++;
         $display("FAIL single_t2: valid=%b data=%0d cnt=%0d ovf=%b, required 1/2/1/0",
                  out_valid, $signed(out_data), out_cnt, out_ovf);
      end
      drain();
   endtask

   task automatic test_four_beats();
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) send_beat(16'd1, 16'd2, 16'd1, 16'd1, i == 3);
      @(negedge clk); in_valid = 1'b0; #1;
      total++;
      if (in_ready !== 1'b1) begin
         bad++; $display("FAIL four_in_ready: in_ready=%b, required 1", in_ready);
      end
      @(negedge clk); #1;
      total++;
      if (out_valid !== 1'b1 || out_data !== ACC_W'(12) || out_cnt !== CNT_W'(4) || in_ready !== 1'b1) begin
         bad++;
         $display("FAIL four_result: valid=%b data=%0d cnt=%0d in_ready=%b, required 1/12/4/1",
                  out_valid, $signed(out_data), out_cnt, in_ready);
      end
      drain();
   endtask

   task automatic test_back_to_back();
      out_ready = 1'b0;
      send_beat(16'd5, 16'd0, 16'd5, 16'd0, 1'b1);
      send_beat(16'd7, 16'd0, 16'd7, 16'd0, 1'b1);
      @(negedge clk); in_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         if (i > 0) @(negedge clk);
         #1;
         total++;
         if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== ACC_W'(25)) begin
            bad++;
            $display("FAIL b2b_hold%0d: in_ready=%b valid=%b data=%0d, required 0/1/25",
                     i, in_ready, out_valid, $signed(out_data));
         end
      end
      @(negedge clk); out_ready = 1'b1;
      @(negedge clk); #1;
      total++;
      if (out_valid !== 1'b1 || out_data !== ACC_W'(49) || out_cnt !== CNT_W'(1)) begin
         bad++;
         $display("FAIL b2b_second: valid=%b data=%0d cnt=%0d, required 1/49/1",
                  out_valid, $signed(out_data), out_cnt);
      end
      drain();
   endtask

   task automatic test_saturate();
      out_ready = 1'b1;
      for (int i = 0; i < 5; i++) send_beat(16'h8000, 16'h8000, 16'h8000, 16'h8000, i == 4);
      @(negedge clk); in_valid = 1'b0;
      @(negedge clk); #1;
      total++;
      if (out_valid !== 1'b1 || out_data !== SAT_MAX || out_ovf !== 1'b1 || out_cnt !== CNT_W'(5)) begin
         bad++;
         $display("FAIL sat_result: valid=%b data=%0d cnt=%0d ovf=%b, required 1/%0d/5/1",
                  out_valid, $signed(out_data), out_cnt, out_ovf, SMAX);
      end
      send_beat(16'd1, 16'd0, 16'd1, 16'd0, 1'b1);
      @(negedge clk); in_valid = 1'b0;
      @(negedge clk); #1;
      total++;
      if (out_valid !== 1'b1 || out_data !== ACC_W'(1) || out_ovf !== 1'b0) begin
         bad++;
         $display("FAIL sat_next: valid=%b data=%0d ovf=%b, required 1/1/0",
                  out_valid, $signed(out_data), out_ovf);
      end
      drain();
   endtask

   task automatic test_cnt_sat();
      out_ready = 1'b1;
      for (int i = 0; i < 300; i++) begin
         send_beat(16'd0, 16'd0, 16'd0, 16'd0, i == 299);
         if (i == 2) begin
            total++;
            if (dbg_state !== 1'b1) begin
               bad++; $display("FAIL cnt_state_run: state=%b, required 1", dbg_state);
            end
         end
      end
      @(negedge clk); in_valid = 1'b0;
      @(negedge clk); #1;
      total++;
      if (out_valid !== 1'b1 || out_data !== '0 || out_cnt !== '1 || out_ovf !== 1'b0) begin
         bad++;
         $display("FAIL cnt_sat: valid=%b data=%0d cnt=%0d ovf=%b, required 1/0/255/0",
                  out_valid, $signed(out_data), out_cnt, out_ovf);
      end
      drain();
   endtask

   task automatic test_reset_mid();
      // A held result plus a beat waiting in the pipeline, then reset.
      out_ready = 1'b0;
      send_beat(16'd10, 16'd0, 16'd10, 16'd0, 1'b1);
      send_beat(16'd4, 16'd0, 16'd4, 16'd0, 1'b0);
      @(negedge clk); in_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b0; #1;
      total++;
      if ({out_valid, out_data, out_cnt, out_ovf} !== '0 || in_ready !== 1'b1) begin
         bad++;
         $display("FAIL rst_held: valid=%b data=%0d cnt=%0d ovf=%b in_ready=%b, required 0/0/0/0/1",
                  out_valid, out_data, out_cnt, out_ovf, in_ready);
      end
      model_clear();
      @(negedge clk); rst_n = 1'b1;
      // Two beats of a three-beat dot product, then reset.
      out_ready = 1'b1;
      send_beat(16'd1, 16'd1, 16'd1, 16'd1, 1'b0);
      send_beat(16'd1, 16'd1, 16'd1, 16'd1, 1'b0);
      @(negedge clk); in_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b0; #1;
      total++;
      if ({out_valid, out_data, out_cnt, out_ovf, dbg_state} !== '0) begin
         bad++;
         $display("FAIL rst_mid: valid=%b data=%0d cnt=%0d ovf=%b state=%b, required all 0",
                  out_valid, out_data, out_cnt, out_ovf, dbg_state);
      end
      model_clear();
      @(negedge clk); rst_n = 1'b1;
      send_beat(16'd2, 16'd0, 16'd3, 16'd0, 1'b1);
      @(negedge clk); in_valid = 1'b0;
      @(negedge clk); #1;
      total++;
      if (out_valid !== 1'b1 || out_data !== ACC_W'(6) || out_cnt !== CNT_W'(1) || out_ovf !== 1'b0) begin
         bad++;
         $display("FAIL rst_after: valid=%b data=%0d cnt=%0d ovf=%b, required 1/6/1/0",
                  out_valid, $signed(out_data), out_cnt, out_ovf);
      end
      drain();
   endtask

   task automatic test_random();
      rdy_rand = 1'b1;
      for (int d = 0; d < 1000; d++) begin
         int nb;
         nb = $urandom_range(1, 6);
         for (int b = 0; b < nb; b++) begin
            if ($urandom_range(0, 3) == 0) begin
               @(negedge clk); in_valid = 1'b0;
            end
            send_beat(rnd_op(), rnd_op(), rnd_op(), rnd_op(), b == nb - 1);
         end
      end
      @(negedge clk); in_valid = 1'b0;
      rdy_rand = 1'b0;
      drain();
   endtask

   initial begin
      test_reset();
      test_single();
      test_four_beats();
      test_back_to_back();
      test_saturate();
      test_cnt_sat();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
